// File: rtl/fft_result_serializer_if.sv
// Sample stream interface for fft_result_serializer: one complex sample per beat,
// tagged with its lane index and an end-of-frame marker.
interface fft_result_serializer_if #(
    parameter int formatWidth = 9,
    parameter int LANES       = 32
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    // A beat transfers on each rising edge where m_valid and m_ready are both high;
    // while m_valid is high and m_ready is low the master holds all payload stable.
    logic                   m_valid;
    logic                   m_ready;
    logic [formatWidth-1:0] m_real;
    logic [formatWidth-1:0] m_imag;
    logic [IDX_W-1:0]       m_index;
    logic                   m_last;

    modport master (
        output m_valid, m_real, m_imag, m_index, m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_real, m_imag, m_index, m_last,
        output m_ready
    );
endinterface

// File: rtl/fft_result_serializer.sv
// Captures packed FFT output vectors on the rising edge of fft_done into a
// two-entry frame buffer and streams them out lane by lane.
module fft_result_serializer #(
    parameter int formatWidth = 9,
    parameter int LANES       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fft_done,
    input  logic [formatWidth*LANES-1:0] output_real_all,
    input  logic [formatWidth*LANES-1:0] output_imag_all,
    fft_result_serializer_if.master      m,
    output logic                         overflow,
    output logic [7:0]                   drop_count
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int VEC_W = formatWidth * LANES;

    logic [VEC_W-1:0] buf_real [2];
    logic [VEC_W-1:0] buf_imag [2];

    logic             done_q;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [IDX_W-1:0] rd_idx;

    logic             capture;
    logic             xfer;
    logic             last_xfer;
    logic             store;
    logic             drop;

    logic [formatWidth-1:0] lane_real [LANES];
    logic [formatWidth-1:0] lane_imag [LANES];

    assign capture   = fft_done && !done_q;
    assign xfer      = m.m_valid && m.m_ready;
    assign last_xfer = xfer && m.m_last;
    // A full buffer still accepts a frame if the oldest one drains on the same edge.
    assign store     = capture && ((count != 2'd2) || last_xfer);
    assign drop      = capture && (count == 2'd2) && !last_xfer;

    always_ff @(posedge clk) begin
        if (!rst) begin
            done_q     <= 1'b1;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            rd_idx     <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            done_q   <= fft_done;
            overflow <= drop;
            if (drop && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
            if (store)
                wr_ptr <= ~wr_ptr;
            if (xfer) begin
                if (m.m_last) begin
                    rd_idx <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    rd_idx <= rd_idx + IDX_W'(1);
                end
            end
            case ({store, last_xfer})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Frame storage carries no reset; its contents are only observed while count != 0.
    always_ff @(posedge clk) begin
        if (rst && store) begin
            buf_real[wr_ptr] <= output_real_all;
            buf_imag[wr_ptr] <= output_imag_all;
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_real[k] = buf_real[rd_ptr][formatWidth*(LANES-1-k) +: formatWidth];
            lane_imag[k] = buf_imag[rd_ptr][formatWidth*(LANES-1-k) +: formatWidth];
        end
    end

    assign m.m_valid = (count != 2'd0);
    assign m.m_real  = lane_real[rd_idx];
    assign m.m_imag  = lane_imag[rd_idx];
    assign m.m_index = rd_idx;
    assign m.m_last  = m.m_valid && (rd_idx == IDX_W'(LANES-1));
endmodule

// File: tb/tb_fft_result_serializer.sv
// Directed bench for fft_result_serializer: frames are pushed into an expected
// queue at stimulus time and a negedge monitor pops and compares every beat.
module tb_fft_result_serializer;
  localparam int FW    = 9;
  localparam int LN    = 32;
  localparam int IW    = 5;
  localparam int VW    = FW * LN;
  localparam int EW    = 2 * FW + IW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fft_done = 1'b0;
  logic [VW-1:0] output_real_all = '0;
  logic [VW-1:0] output_imag_all = '0;
  logic          overflow;
  logic [7:0]    drop_count;

  fft_result_serializer_if #(.formatWidth(FW), .LANES(LN)) s_if ();

  fft_result_serializer #(.formatWidth(FW), .LANES(LN)) dut (
    .clk             (clk),
    .rst             (rst),
    .fft_done        (fft_done),
    .output_real_all (output_real_all),
    .output_imag_all (output_imag_all),
    .m               (s_if.master),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int ovf_cycles = 0;
  logic [EW-1:0] exp_q[$];

  // scoreboard monitor
  logic          stalled_prev = 1'b0;
  logic [EW-1:0] held;
  logic [EW-1:0] cur;
  logic [EW-1:0] exp_v;

  always @(negedge clk) begin
    if (rst) begin
      cur = {s_if.m_real, s_if.m_imag, s_if.m_index, s_if.m_last};
      if (s_if.m_valid) valid_cycles++;
      if (overflow) ovf_cycles++;
      if (s_if.m_valid && stalled_prev) begin
        checks++;
        if (cur !== held) begin
          errors++;
          $display("FAIL stall_stable: got %h required %h", cur, held);
        end
      end
      if (s_if.m_valid && s_if.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h required no beat", cur);
        end else begin
          exp_v = exp_q.pop_front();
          if (cur !== exp_v) begin
            errors++;
            $display("FAIL beat: got real=%0d imag=%0d idx=%0d last=%0d required real=%0d imag=%0d idx=%0d last=%0d",
                     cur[EW-1 -: FW], cur[EW-FW-1 -: FW], cur[IW:1], cur[0],
                     exp_v[EW-1 -: FW], exp_v[EW-FW-1 -: FW], exp_v[IW:1], exp_v[0]);
          end
        end
      end
      stalled_prev = s_if.m_valid && !s_if.m_ready;
      held = cur;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    fft_done = 1'b0;
    s_if.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("reset_valid", {31'd0, s_if.m_valid}, 0);
    check("reset_drop_count", {24'd0, drop_count}, 0);
    check("reset_overflow", {31'd0, overflow}, 0);
  endtask

  // Loads the input vectors; optionally records the frame as expected output.
  task automatic load_frame(input int rbase, input int ibase, input bit expect_out);
    logic [FW-1:0] r;
    logic [FW-1:0] i;
    logic [IW-1:0] idx;
    for (int k = 0; k < LN; k++) begin
      r = FW'(rbase + k);
      i = FW'(ibase + k);
      idx = IW'(k);
      output_real_all[FW*(LN-1-k) +: FW] = r;
      output_imag_all[FW*(LN-1-k) +: FW] = i;
      if (expect_out) exp_q.push_back({r, i, idx, (k == LN-1)});
    end
  endtask

  task automatic pulse_done();
    @(posedge clk);
    #1 fft_done = 1'b1;
    @(posedge clk);
    #1 fft_done = 1'b0;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  int n;
  int guard;

  initial begin
    s_if.m_ready = 1'b0;
    reset_dut();

    // single frame, ready high
    load_frame(0, 100, 1'b1);
    s_if.m_ready = 1'b1;
    valid_cycles = 0;
    pulse_done();
    @(negedge clk);
    check("first_latency_valid", {31'd0, s_if.m_valid}, 1);
    check("first_index", {27'd0, s_if.m_index}, 0);
    #1;
    drain(n);
    check("single_cycles", n, 32);
    @(negedge clk);
    check("single_valid_after", {31'd0, s_if.m_valid}, 0);
    check("single_valid_cycles", valid_cycles, 32);

    // backpressure, ready toggling
    reset_dut();
    load_frame(0, 100, 1'b1);
    s_if.m_ready = 1'b1;
    valid_cycles = 0;
    pulse_done();
    s_if.m_ready = 1'b0;
    guard = 0;
    do begin
      @(posedge clk);
      #1 s_if.m_ready = ~s_if.m_ready;
      guard++;
    end while (s_if.m_valid && guard < 200);
    s_if.m_ready = 1'b0;
    check("bp_left", exp_q.size(), 0);
    check("bp_valid_cycles", valid_cycles, 64);

    // overflow: third frame dropped
    reset_dut();
    ovf_cycles = 0;
    load_frame(0, 100, 1'b1);
    pulse_done();
    load_frame(200, 300, 1'b1);
    pulse_done();
    load_frame(400, 50, 1'b0);
    pulse_done();
    @(negedge clk);
    check("ovf_pulse_now", {31'd0, overflow}, 1);
    repeat (3) @(negedge clk);
    check("ovf_cycles", ovf_cycles, 1);
    check("ovf_drop_count", {24'd0, drop_count}, 1);
    @(posedge clk);
    #1 s_if.m_ready = 1'b1;
    drain(n);
    check("ovf_two_frames_cycles", n, 64);
    @(negedge clk);
    check("ovf_valid_after", {31'd0, s_if.m_valid}, 0);
    s_if.m_ready = 1'b0;

    // capture on the same edge as the last beat of a full buffer
    reset_dut();
    ovf_cycles = 0;
    load_frame(0, 100, 1'b1);
    pulse_done();
    load_frame(200, 300, 1'b1);
    pulse_done();
    load_frame(40, 450, 1'b1);
    @(posedge clk);
    #1 s_if.m_ready = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(s_if.m_valid && s_if.m_index == IW'(LN-1)) && guard < 100);
    check("sim_found_last", {31'd0, s_if.m_last}, 1);
    fft_done = 1'b1;
    @(posedge clk);
    #1 fft_done = 1'b0;
    drain(n);
    @(negedge clk);
    check("sim_valid_after", {31'd0, s_if.m_valid}, 0);
    check("sim_ovf_cycles", ovf_cycles, 0);
    check("sim_drop_count", {24'd0, drop_count}, 0);
    s_if.m_ready = 1'b0;

    // reset mid-frame with fft_done held high
    reset_dut();
    load_frame(0, 100, 1'b1);
    s_if.m_ready = 1'b1;
    pulse_done();
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(s_if.m_valid && s_if.m_index == IW'(10)) && guard < 100);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_if.m_ready = 1'b0;
    fft_done = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    check("mid_consumed", exp_q.size(), 21);
    exp_q.delete();
    valid_cycles = 0;
    @(negedge clk);
    check("mid_valid_after_reset", {31'd0, s_if.m_valid}, 0);
    check("mid_drop_count", {24'd0, drop_count}, 0);
    repeat (5) @(negedge clk);
    check("mid_no_capture_held", valid_cycles, 0);
    load_frame(7, 77, 1'b1);
    s_if.m_ready = 1'b1;
    @(posedge clk);
    #1 fft_done = 1'b0;
    pulse_done();
    drain(n);
    check("mid_recapture_cycles", n, 32);
    @(negedge clk);
    check("mid_valid_end", {31'd0, s_if.m_valid}, 0);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
